// File: rtl/cla_word_sequencer.sv
// Multi-cycle WORDS x 16-bit adder/subtractor sharing one 16-bit carry-lookahead adder.
// Optional signed-overflow output is enabled by defining CLA_SEQ_OVERFLOW_EN.

module sixteen_bit_cla_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  // Four-bit lookahead: returns carries c0..c4 for the given generate/propagate.
  function automatic logic [4:0] lookahead(input logic [3:0] g, input logic [3:0] p, input logic c);
    logic [4:0] r;
    r[0] = c;
    r[1] = g[0] | (p[0] & c);
    r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c);
    return r;
  endfunction

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [15:0] c_s;
  logic [3:0]  gg_s;
  logic [3:0]  pg_s;
  logic [4:0]  gc_s;
  logic [4:0]  lc_s [4];

  assign g_s  = a & b;
  assign p_s  = a ^ b;
  assign gc_s = lookahead(gg_s, pg_s, cin);

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [4:0] grp_s;
    assign grp_s               = lookahead(g_s[4*k +: 4], p_s[4*k +: 4], 1'b0);
    assign gg_s[k]             = grp_s[4];
    assign pg_s[k]             = &p_s[4*k +: 4];
    assign lc_s[k]             = lookahead(g_s[4*k +: 4], p_s[4*k +: 4], gc_s[k]);
    assign c_s[4*k +: 4]       = lc_s[k][3:0];
  end

  assign sum  = p_s ^ c_s;
  assign cout = gc_s[4];
endmodule

module cla_word_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                cout
`ifdef CLA_SEQ_OVERFLOW_EN
  ,
  output logic                ovf
`endif
);
  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [IW-1:0] idx_r;
  logic          carry_r;
  logic          sub_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  work_r;
  logic [W-1:0]  work_next_s;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          busy_r;
  logic          done_r;
  logic [15:0]   b_word_s;
  logic [15:0]   add_sum_s;
  logic          add_cout_s;

  // Operands shift down one word per RUN cycle, so the adder always sees bits [15:0];
  // results enter from the top and are aligned after WORDS shifts.
  assign b_word_s    = b_r[15:0] ^ {16{sub_r}};
  assign work_next_s = {add_sum_s, work_r[W-1:16]};

  sixteen_bit_cla_adder u_cla (
    .a    (a_r[15:0]),
    .b    (b_word_s),
    .cin  (carry_r),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, work registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      sub_r   <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      work_r  <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            carry_r <= sub ? 1'b1 : cin;
            idx_r   <= '0;
            work_r  <= '0;
          end
        end
        RUN: begin
          a_r     <= {16'h0000, a_r[W-1:16]};
          b_r     <= {16'h0000, b_r[W-1:16]};
          work_r  <= work_next_s;
          carry_r <= add_cout_s;
          // Results are loaded on the last RUN edge so they are already valid while done is high.
          if (idx_r == LAST_IDX) begin
            sum_r  <= work_next_s;
            cout_r <= add_cout_s;
`ifdef CLA_SEQ_OVERFLOW_EN
            ovf    <= (a_r[15] == b_word_s[15]) && (add_sum_s[15] != a_r[15]);
`endif
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Randomized self-checking bench for cla_word_sequencer (WORDS=4) against a cycle-count
// reference model built from plain wide arithmetic; directed vectors pin the model.
module tb_cla_word_sequencer;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  bit           pend = 1'b0;
  bit           idle_now;
  int           acc = 0;
  logic [W:0]   res_q;
  logic         res_ovf_q;
  logic [W-1:0] bp;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;

  cla_word_sequencer #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef CLA_SEQ_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

`ifndef CLA_SEQ_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = ONES;
      1:       v = '0;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Reference model: an operation accepted in cycle c has done in cycle c+WORDS+1.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        pend = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else begin
        idle_now = !pend;
        if (pend && cyc == acc + WORDS + 1) pend = 1'b0;
        if (idle_now && start) begin
          acc   = cyc;
          pend  = 1'b1;
          bp    = sub ? ~b : b;
          res_q = {1'b0, a} + {1'b0, bp} + (W+1)'(sub ? 1'b1 : cin);
          res_ovf_q = (a[W-1] == bp[W-1]) && (res_q[W-1] != a[W-1]);
        end
        exp_done = pend && (cyc + 1 == acc + WORDS + 1);
        exp_busy = pend;
        if (exp_done) begin
          m_sum = res_q[W-1:0]; m_cout = res_q[W]; m_ovf = res_ovf_q;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("busy", (W+1)'(busy), (W+1)'(exp_busy));
        chk("done", (W+1)'(done), (W+1)'(exp_done));
        chk("sum",  {1'b0, sum},  {1'b0, m_sum});
        chk("cout", (W+1)'(cout), (W+1)'(m_cout));
`ifdef CLA_SEQ_OVERFLOW_EN
        chk("ovf",  (W+1)'(ovf),  (W+1)'(m_ovf));
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                        input logic tcin, input logic [W-1:0] esum, input logic ecout,
                        input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_latency"}, (W+1)'(n), (W+1)'(WORDS));
    chk({name, "_sum"}, {1'b0, sum}, {1'b0, esum});
    chk({name, "_cout"}, (W+1)'(cout), (W+1)'(ecout));
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, (W+1)'(done), (W+1)'(1'b0));
  endtask

  initial begin
    int nd;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", (W+1)'(busy), (W+1)'(1'b0));
    chk("reset_sum", {1'b0, sum}, '0);
    chk("reset_ovf", (W+1)'(ovf), (W+1)'(1'b0));

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, "carry_word");
    run_op(ONES, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, "ripple_cin");
    run_op(ONES, ONES, 1'b0, 1'b1, ONES, 1'b1, "ripple_ones");
    run_op(64'h0000_0000_0001_0000, 64'h1, 1'b1, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, "sub_basic");
    run_op(64'h0, 64'h1, 1'b1, 1'b0, ONES, 1'b0, "sub_borrow");
`ifdef CLA_SEQ_OVERFLOW_EN
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, "ovf_add");
    chk("ovf_add_flag", (W+1)'(ovf), (W+1)'(1'b1));
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "ovf_sub");
    chk("ovf_sub_flag", (W+1)'(ovf), (W+1)'(1'b1));
`endif

    // Start while busy is ignored
    a = 64'h1234; b = 64'h1; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 64'h5555; b = 64'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        nd++;
        chk("busy_start_sum", {1'b0, sum}, (W+1)'(64'h1235));
        @(posedge clk); #1;
        chk("busy_drop", (W+1)'(busy), (W+1)'(1'b0));
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("busy_start_one_done", (W+1)'(nd), (W+1)'(1));

    // Reset in the second RUN cycle
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", (W+1)'(busy), (W+1)'(1'b0));
    chk("abort_sum", {1'b0, sum}, '0);
    chk("abort_cout", (W+1)'(cout), (W+1)'(1'b0));
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) nd++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", (W+1)'(nd), (W+1)'(0));
    run_op(64'd100, 64'd23, 1'b0, 1'b0, 64'd123, 1'b0, "after_abort");

    // Start held high: back-to-back operations
    a = 64'h1; b = 64'h2; sub = 1'b0; cin = 1'b1; start = 1'b1;
    repeat (3 * (WORDS + 2)) begin
      @(posedge clk); #1;
      a = rnd_op(); b = rnd_op(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 3) != 0);
      a     = rnd_op();
      b     = rnd_op();
      sub   = 1'($urandom_range(0, 1));
      cin   = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    repeat (WORDS + 4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cla_word_sequencer.md
# cla_word_sequencer

Multi-cycle wide-operand adder/subtractor built around a single instance of the existing 16-bit carry-lookahead adder (`sixteen_bit_cla_adder`). The block accepts a WORDS×16-bit operand pair, feeds it through the shared 16-bit adder one word per cycle, least-significant word first, and chains the carry between words. It sits between a requesting unit that issues a `start` pulse and the CLA datapath. It returns a registered result with a one-cycle `done` pulse.

## Interface
- `WORDS`, default 4: number of 16-bit words per operand. Legal range 2..16. Operand width is W = 16×WORDS.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `sub`  in  1  operation select: 0 = A+B+cin, 1 = A−B (two's complement).
- `a`  in  W  operand A; sampled with `start`.
- `b`  in  W  operand B; sampled with `start`.
- `cin`  in  1  carry-in; used only when `sub`=0.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid from this cycle onward.
- `sum`  out  W  result; holds its value until the next `done`.
- `cout`  out  1  carry out of word WORDS−1.
- `ovf`  out  1  signed overflow (present only with `CLA_SEQ_OVERFLOW_EN`).

## Operation
- FSM states:
  - IDLE: `busy`=0. If `start`=1, latch `a`, `b`, `sub` into work registers. Latch the initial carry as `sub` ? 1 : `cin`. Set index to 0. Go to RUN.
  - RUN: `busy`=1. Drive the adder with A[idx], the B word (B[idx] if `sub`=0, ~B[idx] if `sub`=1), and the carry register. Write the adder sum into work-sum word idx and write the adder cout into the carry register. If idx=WORDS−1, go to DONE; otherwise increment idx.
  - DONE: `busy`=1 and `done`=1. Copy the work sum to `sum` and the carry register to `cout` (and compute `ovf`). Return to IDLE.
- `start` is ignored in RUN and DONE; no queuing.
- The index counter is ceil(log2(WORDS)) bits wide and never wraps past WORDS−1.
- Subtraction convention: `cout`=1 means no borrow (A ≥ B unsigned).
- Input operands may change freely after acceptance; only the latched copies are used.

## Timing
- Reset: state=IDLE, index=0, carry=0, all work registers 0. Outputs after reset: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
- Latency: if `start` is accepted in cycle k, RUN occupies cycles k+1..k+WORDS and `done` is high in cycle k+WORDS+1.
- Throughput: one operation per WORDS+2 cycles. The earliest next `start` is accepted in cycle k+WORDS+2.
- `done` is never high for two consecutive cycles.
- Reset mid-operation (RUN or DONE) aborts the operation. Next cycle: IDLE, outputs at reset values, no `done` pulse. Reset has priority over `start`.
- `start` held high continuously: one operation is accepted each time the FSM returns to IDLE.

## Configuration
- Macro `CLA_SEQ_OVERFLOW_EN`.
- With the macro defined: the `ovf` port exists. In DONE, `ovf` is registered as (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the post-inversion operand. `ovf` holds with `sum` and resets to 0.
- Without the macro: no `ovf` port and no overflow logic. All other behaviour is identical.

## Test plan
All scenarios use WORDS=4.
- Carry across a word boundary: A=0x0000_0000_0000_FFFF, B=0x1, cin=0, sub=0 → `sum`=0x0000_0000_0001_0000, `cout`=0. `done` arrives exactly 5 cycles after the accepting cycle and lasts one cycle.
- Full-width ripple with carry-in: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → `sum`=0, `cout`=1. A second run with A=B=0xFFFF_FFFF_FFFF_FFFF, cin=1 → `sum`=0xFFFF_FFFF_FFFF_FFFF, `cout`=1.
- Subtract: sub=1, A=0x0000_0000_0001_0000, B=0x1, cin=1 (ignored) → `sum`=0x0000_0000_0000_FFFF, `cout`=1. A second run with A=0, B=1 → `sum`=0xFFFF_FFFF_FFFF_FFFF, `cout`=0.
- Start while busy: accept A=0x1234, B=0x1. Two cycles later pulse `start` with A=0x5555, B=0x5555 → only one `done`, with `sum`=0x1235; `busy` drops the cycle after `done`.
- Reset mid-operation: accept an operation, then assert `rst` in the second RUN cycle → next cycle `busy`=0, `sum`=0, `cout`=0. No `done` appears within 10 cycles. A fresh `start` afterwards completes normally.
- Overflow (macro defined): A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, sub=0 → `sum`=0x8000_0000_0000_0000, `ovf`=1, `cout`=0. Then sub=1, A=0x8000_0000_0000_0000, B=0x1 → `ovf`=1.
